// File: rtl/rf_mp.sv
// Multi-port register file: NR async read ports, two byte-enabled write ports,
// optional write-to-read bypass, optional hardwired-zero entry 0 and a clear sweep.
module rf_mp #(
  parameter int AW      = 5,
  parameter int DW      = 16,
  parameter int NR      = 2,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*DW-1:0]   rd,
  input  logic               we0,
  input  logic [AW-1:0]      wa0,
  input  logic [DW-1:0]      wd0,
  input  logic [DW/8-1:0]    wbe0,
  input  logic               we1,
  input  logic [AW-1:0]      wa1,
  input  logic [DW-1:0]      wd1,
  input  logic [DW/8-1:0]    wbe1,
  input  logic               clr,
  output logic               busy
);

  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  logic [DW-1:0] r_mem [DEPTH];
  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;

  logic w_wen0;
  logic w_wen1;

  // A write only lands while idle and outside reset; entry 0 is read-only when hardwired
  assign w_wen0 = we0 && (r_state == S_IDLE) && !rst &&
                  !((ZERO_R0 != 0) && (wa0 == {AW{1'b0}}));
  assign w_wen1 = we1 && (r_state == S_IDLE) && !rst &&
                  !((ZERO_R0 != 0) && (wa1 == {AW{1'b0}}));

  assign busy = r_busy;

  // Storage, clear-sweep FSM and busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= {AW{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= {AW{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
          // port 1 is applied last so it wins lanes enabled on both ports
          for (int k = 0; k < BW; k++) begin
            if (w_wen0 && wbe0[k]) begin
              r_mem[wa0][k*8 +: 8] <= wd0[k*8 +: 8];
            end
          end
          for (int k = 0; k < BW; k++) begin
            if (w_wen1 && wbe1[k]) begin
              r_mem[wa1][k*8 +: 8] <= wd1[k*8 +: 8];
            end
          end
        end
        S_CLEAR: begin
          if (clr) begin
            r_ptr <= {AW{1'b0}};
          end else begin
            r_mem[r_ptr] <= {DW{1'b0}};
            r_ptr        <= r_ptr + AW'(1);
            if (r_ptr == PTR_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_busy  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ptr   <= {AW{1'b0}};
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_old;
    logic [DW-1:0] w_merged;
    logic [DW-1:0] w_val;

    assign w_ra  = ra[i*AW +: AW];
    assign w_old = r_mem[w_ra];

    for (genvar k = 0; k < BW; k++) begin : g_lane
      assign w_merged[k*8 +: 8] =
        (w_wen1 && wbe1[k] && (wa1 == w_ra)) ? wd1[k*8 +: 8] :
        (w_wen0 && wbe0[k] && (wa0 == w_ra)) ? wd0[k*8 +: 8] :
                                                w_old[k*8 +: 8];
    end

    // Read mux: blanked while sweeping or for hardwired entry 0, else stored or forwarded
    always_comb begin
      w_val = {DW{1'b0}};
      if (r_busy) begin
        w_val = {DW{1'b0}};
      end else if ((ZERO_R0 != 0) && (w_ra == {AW{1'b0}})) begin
        w_val = {DW{1'b0}};
      end else if (BYPASS != 0) begin
        w_val = w_merged;
      end else begin
        w_val = w_old;
      end
    end

    assign rd[i*DW +: DW] = w_val;
  end

endmodule
